pattern_bist_ctrl: RTL and testbench
====================================

Name: pattern_bist_ctrl

Overview:
Built-in self-test sequencer for the merged sequential/combinational pattern circuits.
- Generates pseudo-random input vectors with an LFSR and drives them into the pattern circuit.
- Waits a programmable settle time, then compacts the circuit outputs into a MISR signature.
- Repeats for NUM_PAT vectors, then compares the signature against a golden value and reports pass/fail.
- Sits between the test-access wrapper and one pattern-merge netlist instance; also owns that instance's reset.

Parameters:
IN_W, 15, width of vector driven to the pattern circuit
OUT_W, 12, width of pattern-circuit outputs compacted
CNT_W, 16, pattern counter width
NUM_PAT, 256, vectors per run (1..2^CNT_W-1)
SETTLE, 2, wait cycles between APPLY and CAPTURE (0..15)
LFSR_SEED, 15'h0001, LFSR start value (0 substituted by 1)
LFSR_TAPS, 15'h6000, Fibonacci tap mask (x^15+x^14+1)
MISR_TAPS, 12'hE08, MISR feedback tap mask
GOLDEN_SIG, 12'h000, expected final signature

Ports:
blif_clk_net  in  1  clock, all flops rising edge
blif_reset_net  in  1  asynchronous active-high reset
start  in  1  begin run; sampled in IDLE or DONE only
abort  in  1  synchronous abort to IDLE
dut_out  in  OUT_W  pattern-circuit outputs
dut_in  out  IN_W  vector to pattern circuit
dut_reset  out  1  reset to pattern circuit, active-high, registered
busy  out  1  high in INIT/APPLY/SETTLE/CAPTURE/CHECK
done  out  1  high in DONE
pass  out  1  valid when done; signature==GOLDEN_SIG
signature  out  OUT_W  current MISR value
pat_count  out  CNT_W  vectors captured so far

Behaviour:
Reset values:
- dut_in=0, dut_reset=1, busy=0, done=0, pass=0, signature=0, pat_count=0.
- Internal LFSR=LFSR_SEED, state=IDLE.
- Reset is effective immediately at any point, mid-run included. No partial result is retained.

Outputs and datapath rules:
- dut_in = LFSR register while busy; 0 otherwise.
- LFSR step: lfsr <= {lfsr[IN_W-2:0], ^(lfsr & LFSR_TAPS)}.
- MISR step: sig <= {sig[OUT_W-2:0], ^(sig & MISR_TAPS)} ^ dut_out.

FSM:
- IDLE: dut_reset=0. On start: go to INIT, load lfsr=seed, sig=0, pat_count=0, pass=0.
- INIT: 2 cycles, dut_reset=1. Then APPLY.
- APPLY: 1 cycle. dut_in stable. Then SETTLE, or CAPTURE if SETTLE=0.
- SETTLE: SETTLE cycles, using a 4-bit wait counter. Then CAPTURE.
- CAPTURE: 1 cycle. On the exit edge: MISR samples dut_out, pat_count++, LFSR steps. If pat_count==NUM_PAT-1 before the increment, go to CHECK; else go to APPLY.
- CHECK: 1 cycle. pass <= (sig==GOLDEN_SIG). Then DONE.
- DONE: done=1. pass and signature are held. start restarts the run exactly as from IDLE.

Timing:
- Run latency from the edge sampling start to done=1 is 2 + NUM_PAT*(SETTLE+2) + 1 clocks.

Boundary conditions:
- start while busy: ignored.
- abort in any busy state: next state IDLE, done=0, pass=0, dut_reset=0. signature and pat_count are frozen at their values for inspection.
- abort and start in the same cycle: abort wins.
- abort in IDLE or DONE: go to IDLE and clear done/pass.
- pat_count never wraps: NUM_PAT ≤ 2^CNT_W-1 is a parameter legality check (elaboration error otherwise).
- dut_out is sampled only on the CAPTURE exit edge. Values during APPLY/SETTLE are ignored.
- start held high through DONE: one new run per rising level is not required. Each cycle in DONE with start=1 begins a new run.

Test Plan:
- Common setup for the directed scenarios: NUM_PAT=4, SETTLE=1, seed 15'h0001; bench stub dut_out = ~dut_in[11:0].
1. Directed run -> dut_in sequence 0001,0002,0004,0008; signature after each capture FFE,001,FF9,005; done=1 exactly 15 clocks after start is sampled; pat_count=4.
2. Same run with GOLDEN_SIG=12'h005 -> pass=1; with GOLDEN_SIG=12'h000 -> pass=0; done held until next start.
3. Reset: assert blif_reset_net during the 2nd SETTLE -> same cycle dut_reset=1, busy=0, signature=0, pat_count=0; after release, IDLE gives dut_reset=0 on first clock.
4. abort during 3rd APPLY -> next cycle IDLE, busy=0, done=0, pat_count=2, signature=001 frozen; abort+start in the same cycle -> remains IDLE.
5. start pulse while busy (during CAPTURE of vector 1) -> no restart; run completes with identical results and timing to scenario 1.
6. SETTLE=0, NUM_PAT=1 -> latency 5 clocks, signature=FFE, INIT shows dut_reset=1 for exactly 2 cycles.

Source files
------------

// File: rtl/pattern_bist_ctrl.sv
// LFSR/MISR BIST sequencer for one pattern-merge netlist instance.
// It drives test vectors, compacts the responses into a signature and owns the instance reset.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for start, pattern circuit out of reset
// S_INIT    | two cycles holding the pattern circuit in reset
// S_APPLY   | vector on dut_in for one cycle
// S_SETTLE  | SETTLE cycles of propagation wait (down-counter)
// S_CAPTURE | MISR samples dut_out, LFSR steps, pattern counted on exit
// S_CHECK   | compare signature against GOLDEN_SIG
// S_DONE    | result held, start re-arms a run
module pattern_bist_ctrl #(
  parameter int IN_W = 15,
  parameter int OUT_W = 12,
  parameter int CNT_W = 16,
  parameter int NUM_PAT = 256,
  parameter int SETTLE = 2,
  parameter logic [IN_W-1:0] LFSR_SEED = 'h0001,
  parameter logic [IN_W-1:0] LFSR_TAPS = 'h6000,
  parameter logic [OUT_W-1:0] MISR_TAPS = 'hE08,
  parameter logic [OUT_W-1:0] GOLDEN_SIG = '0
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             start,
  input  logic             abort,
  input  logic [OUT_W-1:0] dut_out,
  output logic [IN_W-1:0]  dut_in,
  output logic             dut_reset,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature,
  output logic [CNT_W-1:0] pat_count
);

  if (NUM_PAT < 1 || NUM_PAT > (2 ** CNT_W) - 1) begin : g_bad_num_pat
    $error("pattern_bist_ctrl: NUM_PAT out of range for CNT_W");
  end
  if (SETTLE < 0 || SETTLE > 15) begin : g_bad_settle
    $error("pattern_bist_ctrl: SETTLE must be 0..15");
  end

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [IN_W-1:0]  SEED_EFF  = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;
  localparam logic [3:0]       SETTLE_LD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam logic [CNT_W-1:0] LAST_PAT  = CNT_W'(NUM_PAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_APPLY, S_SETTLE, S_CAPTURE, S_CHECK, S_DONE
  } state_t;

  state_t state, state_nxt;
  logic [3:0] wait_cnt, wait_nxt;
  logic [IN_W-1:0] lfsr, lfsr_nxt, lfsr_step;
  logic [OUT_W-1:0] sig, sig_nxt, misr_step;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic pass_q, pass_nxt;
  logic dut_reset_nxt;

  assign lfsr_step = {lfsr[IN_W-2:0], ^(lfsr & LFSR_TAPS)};
  assign misr_step = {sig[OUT_W-2:0], ^(sig & MISR_TAPS)} ^ dut_out;

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      lfsr      <= SEED_EFF;
      sig       <= '0;
      cnt       <= '0;
      pass_q    <= 1'b0;
      dut_reset <= 1'b1;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      lfsr      <= lfsr_nxt;
      sig       <= sig_nxt;
      cnt       <= cnt_nxt;
      pass_q    <= pass_nxt;
      dut_reset <= dut_reset_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    lfsr_nxt  = lfsr;
    sig_nxt   = sig;
    cnt_nxt   = cnt;
    pass_nxt  = pass_q;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_INIT;
          wait_nxt  = 4'd1;
          lfsr_nxt  = SEED_EFF;
          sig_nxt   = '0;
          cnt_nxt   = '0;
          pass_nxt  = 1'b0;
        end
      end
      S_INIT: begin
        if (wait_cnt == 4'd0) state_nxt = S_APPLY;
        else wait_nxt = wait_cnt - 4'd1;
      end
      S_APPLY: begin
        if (SETTLE == 0) begin
          state_nxt = S_CAPTURE;
        end else begin
          state_nxt = S_SETTLE;
          wait_nxt  = SETTLE_LD;
        end
      end
      S_SETTLE: begin
        if (wait_cnt == 4'd0) state_nxt = S_CAPTURE;
        else wait_nxt = wait_cnt - 4'd1;
      end
      S_CAPTURE: begin
        sig_nxt   = misr_step;
        cnt_nxt   = cnt + CNT_W'(1);
        lfsr_nxt  = lfsr_step;
        state_nxt = (cnt == LAST_PAT) ? S_CHECK : S_APPLY;
      end
      S_CHECK: begin
        pass_nxt  = (sig == GOLDEN_SIG);
        state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Abort keeps signature and count where they stopped so they can be inspected.
    if (abort) begin
      state_nxt = S_IDLE;
      wait_nxt  = wait_cnt;
      lfsr_nxt  = lfsr;
      sig_nxt   = sig;
      cnt_nxt   = cnt;
      pass_nxt  = 1'b0;
    end
  end

  assign dut_reset_nxt = (state_nxt == S_INIT);

  assign busy      = (state == S_INIT) || (state == S_APPLY) || (state == S_SETTLE) ||
                     (state == S_CAPTURE) || (state == S_CHECK);
  assign done      = (state == S_DONE);
  assign dut_in    = busy ? lfsr : '0;
  assign pass      = pass_q;
  assign signature = sig;
  assign pat_count = cnt;

endmodule

// File: tb/tb_pattern_bist_ctrl.sv
// Bench for pattern_bist_ctrl: directed scenarios on small configurations plus
// randomized responses checked against a cycle-indexed reference model.
module tb_pattern_bist_ctrl;

  localparam int NP_D = 9;
  localparam int ST_D = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic start_a, abort_a;
  logic [11:0] dut_out_a, sig_a, dut_out_b, sig_b;
  logic [14:0] dut_in_a, dut_in_b;
  logic dut_reset_a, busy_a, done_a, pass_a;
  logic dut_reset_b, busy_b, done_b, pass_b;
  logic [15:0] cnt_a, cnt_b;

  logic start_c, abort_c;
  logic [11:0] dut_out_c, sig_c;
  logic [14:0] dut_in_c;
  logic dut_reset_c, busy_c, done_c, pass_c;
  logic [15:0] cnt_c;

  logic start_d, abort_d;
  logic [11:0] dut_out_d, sig_d;
  logic [14:0] dut_in_d;
  logic dut_reset_d, busy_d, done_d, pass_d;
  logic [15:0] cnt_d;

  assign dut_out_a = ~dut_in_a[11:0];
  assign dut_out_b = ~dut_in_b[11:0];
  assign dut_out_c = ~dut_in_c[11:0];

  pattern_bist_ctrl #(.NUM_PAT(4), .SETTLE(1), .GOLDEN_SIG(12'h005)) u_a (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start_a), .abort(abort_a),
    .dut_out(dut_out_a), .dut_in(dut_in_a), .dut_reset(dut_reset_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .signature(sig_a), .pat_count(cnt_a));

  pattern_bist_ctrl #(.NUM_PAT(4), .SETTLE(1), .GOLDEN_SIG(12'h000)) u_b (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start_a), .abort(abort_a),
    .dut_out(dut_out_b), .dut_in(dut_in_b), .dut_reset(dut_reset_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .signature(sig_b), .pat_count(cnt_b));

  pattern_bist_ctrl #(.NUM_PAT(1), .SETTLE(0), .GOLDEN_SIG(12'h000)) u_c (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start_c), .abort(abort_c),
    .dut_out(dut_out_c), .dut_in(dut_in_c), .dut_reset(dut_reset_c), .busy(busy_c),
    .done(done_c), .pass(pass_c), .signature(sig_c), .pat_count(cnt_c));

  pattern_bist_ctrl #(.NUM_PAT(NP_D), .SETTLE(ST_D), .GOLDEN_SIG(12'h000)) u_d (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start_d), .abort(abort_d),
    .dut_out(dut_out_d), .dut_in(dut_in_d), .dut_reset(dut_reset_d), .busy(busy_d),
    .done(done_d), .pass(pass_d), .signature(sig_d), .pat_count(cnt_d));

  logic [14:0] exp_in [4] = '{15'h0001, 15'h0002, 15'h0004, 15'h0008};
  logic [11:0] exp_sig[4] = '{12'hFFE, 12'h001, 12'hFF9, 12'h005};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: shift left, parity of tapped bits enters at bit 0.
  function automatic logic [14:0] m_lfsr_next(input logic [14:0] l);
    int p;
    p = $countones(l & 15'h6000) % 2;
    return 15'((l * 2) + p);
  endfunction

  function automatic logic [11:0] m_misr_next(input logic [11:0] s, input logic [11:0] d);
    int p;
    p = $countones(s & 12'hE08) % 2;
    return 12'((s * 2) + p) ^ d;
  endfunction

  task automatic run_a(input bit poke);
    int lat;
    lat = -1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("init_busy", busy_a, 1);
    chk("init_dut_reset", dut_reset_a, 1);
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      start_a = poke && (c - 1 == 4);
      tick();
      for (int k = 0; k < 4; k++) begin
        if (c == 2 + 3 * k) chk("apply_dut_in", dut_in_a, exp_in[k]);
        if (c == 5 + 3 * k) begin
          chk("capture_sig", sig_a, exp_sig[k]);
          chk("capture_cnt", cnt_a, k + 1);
        end
      end
      if (done_a) lat = c;
    end
    start_a = 1'b0;
    chk("run_latency", lat, 15);
    chk("run_cnt", cnt_a, 4);
    chk("run_sig", sig_a, 12'h005);
    chk("run_pass_golden005", pass_a, 1);
    chk("run_busy_low", busy_a, 0);
  endtask

  initial begin
    int lat, rc;
    logic [14:0] m_lfsr;
    logic [11:0] m_sig, prev;
    int m_cnt;

    rst = 1'b1;
    start_a = 0; abort_a = 0; start_c = 0; abort_c = 0;
    start_d = 0; abort_d = 0; dut_out_d = '0;
    tick(); tick();
    chk("rst_dut_in", dut_in_a, 0);
    chk("rst_dut_reset", dut_reset_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_sig", sig_a, 0);
    chk("rst_cnt", cnt_a, 0);
    rst = 1'b0;
    tick();
    chk("idle_dut_reset", dut_reset_a, 0);

    // Directed run, both golden values, then a held result.
    run_a(1'b0);
    chk("b_done", done_b, 1);
    chk("b_sig", sig_b, 12'h005);
    chk("b_pass_golden000", pass_b, 0);
    repeat (3) tick();
    chk("hold_done", done_a, 1);
    chk("hold_pass", pass_a, 1);
    chk("hold_sig", sig_a, 12'h005);

    // Restart from DONE with a start pulse landing in CAPTURE of vector 1.
    run_a(1'b1);

    // Asynchronous reset in the second SETTLE.
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (6) tick();
    chk("pre_rst_sig", sig_a, 12'hFFE);
    rst = 1'b1;
    #1;
    chk("mid_rst_dut_reset", dut_reset_a, 1);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_sig", sig_a, 0);
    chk("mid_rst_cnt", cnt_a, 0);
    chk("mid_rst_dut_in", dut_in_a, 0);
    #1;
    rst = 1'b0;
    tick();
    chk("post_rst_dut_reset", dut_reset_a, 0);
    chk("post_rst_busy", busy_a, 0);

    // Abort in the third APPLY, then abort together with start.
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (8) tick();
    chk("pre_abort_dut_in", dut_in_a, 15'h0004);
    abort_a = 1'b1; tick(); abort_a = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_cnt", cnt_a, 2);
    chk("abort_sig", sig_a, 12'h001);
    chk("abort_dut_reset", dut_reset_a, 0);
    chk("abort_dut_in", dut_in_a, 0);
    abort_a = 1'b1; start_a = 1'b1; tick(); abort_a = 1'b0; start_a = 1'b0;
    chk("abort_start_busy", busy_a, 0);
    chk("abort_start_dut_reset", dut_reset_a, 0);
    chk("abort_start_sig", sig_a, 12'h001);
    tick();
    chk("abort_start_idle", busy_a, 0);

    // Abort while DONE clears done and pass.
    run_a(1'b0);
    abort_a = 1'b1; tick(); abort_a = 1'b0;
    chk("abort_done_done", done_a, 0);
    chk("abort_done_pass", pass_a, 0);
    chk("abort_done_sig", sig_a, 12'h005);

    // Minimum configuration: SETTLE=0, one vector.
    start_c = 1'b1; tick(); start_c = 1'b0;
    rc = dut_reset_c ? 1 : 0;
    lat = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      tick();
      if (dut_reset_c) rc++;
      if (done_c) lat = c;
    end
    chk("c_latency", lat, 5);
    chk("c_reset_cycles", rc, 2);
    chk("c_sig", sig_c, 12'hFFE);
    chk("c_cnt", cnt_c, 1);
    chk("c_pass", pass_c, 0);

    // Random responses every cycle, random start pulses while busy.
    for (int r = 0; r < 3; r++) begin
      m_lfsr = 15'h0001;
      m_sig = '0;
      m_cnt = 0;
      lat = 2 + NP_D * (ST_D + 2) + 1;
      dut_out_d = 12'($urandom);
      start_d = 1'b1;
      tick();
      start_d = 1'b0;
      dut_out_d = 12'($urandom);
      for (int c = 1; c <= lat; c++) begin
        prev = dut_out_d;
        start_d = ($urandom_range(0, 3) == 0);
        tick();
        dut_out_d = 12'($urandom);
        if (c >= ST_D + 4 && (c - 2) % (ST_D + 2) == 0 && m_cnt < NP_D) begin
          m_sig = m_misr_next(m_sig, prev);
          m_lfsr = m_lfsr_next(m_lfsr);
          m_cnt++;
        end
        if ((c - 2) % (ST_D + 2) == 0 && c >= 2 && c <= 2 + (NP_D - 1) * (ST_D + 2))
          chk("d_dut_in", dut_in_d, m_lfsr);
        chk("d_busy", busy_d, (c < lat) ? 1 : 0);
        chk("d_done", done_d, (c == lat) ? 1 : 0);
        chk("d_sig", sig_d, m_sig);
        chk("d_cnt", cnt_d, m_cnt);
      end
      start_d = 1'b0;
      chk("d_pass", pass_d, (m_sig == 12'h000) ? 1 : 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
